contador_relogio: RTL and testbench

Timekeeping core of the digital clock, directly downstream of the adjustment block. It captures the six BCD digits produced during adjust mode and loads them on exit from adjust mode. It then advances the time once per second from a prescaled system clock, wrapping 23:59:59 to 00:00:00. Its registered BCD outputs feed the display path.

---
 rtl/contador_relogio.sv | 127 ++++++++++++
 tb/tb_contador_relogio.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_relogio.sv
// Timekeeping core: BCD HH:MM:SS counter advanced once per second from a
// prescaled clock, with shadow capture/validation during adjust and load on exit.
module contador_relogio #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ajMod,
  input  logic [3:0] in_hou_tens,
  input  logic [3:0] in_hou_units,
  input  logic [3:0] in_min_tens,
  input  logic [3:0] in_min_units,
  input  logic [3:0] in_sec_tens,
  input  logic [3:0] in_sec_units,
  output logic [3:0] hou_tens,
  output logic [3:0] hou_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       sec_pulse,
  output logic       day_wrap
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM  = PW'(CLK_HZ - 1);
  localparam logic [3:0]    BLANK = 4'hF;

  typedef enum logic {RUN = 1'b0, ADJUST = 1'b1} mode_t;

  mode_t         mode;
  logic [PW-1:0] presc;
  logic [23:0]   shadow;
  logic [23:0]   shadow_nx;
  logic [23:0]   shadow_base;
  logic [23:0]   cur_time;
  logic [23:0]   in_time;
  logic [23:0]   inc_time;
  logic          entry;
  logic          tick;
  logic          day_end;

  // Hour pair is loadable only when both digits are real and the value is 00..23.
  function automatic logic hours_ok(input logic [3:0] t, input logic [3:0] u);
    return (t != BLANK) && (u != BLANK) && (t <= 4'd2) && (u <= 4'd9) &&
           !((t == 4'd2) && (u > 4'd3));
  endfunction

  function automatic logic sexa_ok(input logic [3:0] t, input logic [3:0] u);
    return (t != BLANK) && (u != BLANK) && (t <= 4'd5) && (u <= 4'd9);
  endfunction

  // Returns {wrapped, next} for one BCD digit counting 0..top.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] top);
    if (d >= top) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  assign cur_time = {hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units};
  assign in_time  = {in_hou_tens, in_hou_units, in_min_tens, in_min_units,
                     in_sec_tens, in_sec_units};
  assign entry    = ajMod && (mode == RUN);
  assign tick     = !ajMod && (mode == RUN) && (presc == TERM);

  always_comb begin
    logic [4:0] su_s, st_s, mu_s, mt_s, hu_s;
    logic       c_st, c_mu, c_mt, c_h;
    su_s     = bcd_step(sec_units, 4'd9);
    st_s     = bcd_step(sec_tens,  4'd5);
    mu_s     = bcd_step(min_units, 4'd9);
    mt_s     = bcd_step(min_tens,  4'd5);
    hu_s     = bcd_step(hou_units, 4'd9);
    c_st     = su_s[4];
    c_mu     = c_st && st_s[4];
    c_mt     = c_mu && mu_s[4];
    c_h      = c_mt && mt_s[4];
    day_end  = c_h && (hou_tens == 4'd2) && (hou_units == 4'd3);
    inc_time = cur_time;
    inc_time[3:0] = su_s[3:0];
    if (c_st) inc_time[7:4]   = st_s[3:0];
    if (c_mu) inc_time[11:8]  = mu_s[3:0];
    if (c_mt) inc_time[15:12] = mt_s[3:0];
    if (day_end) begin
      inc_time[23:16] = 8'h00;
    end else if (c_h) begin
      inc_time[19:16] = hu_s[3:0];
      if (hu_s[4]) inc_time[23:20] = hou_tens + 4'd1;
    end
  end

  // On the entry edge the shadow starts from the running time; valid pairs override.
  always_comb begin
    shadow_base = entry ? cur_time : shadow;
    shadow_nx   = shadow_base;
    if (hours_ok(in_time[23:20], in_time[19:16])) shadow_nx[23:16] = in_time[23:16];
    if (sexa_ok(in_time[15:12], in_time[11:8]))   shadow_nx[15:8]  = in_time[15:8];
    if (sexa_ok(in_time[7:4], in_time[3:0]))      shadow_nx[7:0]   = in_time[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode      <= RUN;
      presc     <= '0;
      shadow    <= '0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      {hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units} <= '0;
    end else begin
      mode      <= ajMod ? ADJUST : RUN;
      sec_pulse <= tick;
      day_wrap  <= tick && day_end;
      if (ajMod) begin
        presc  <= '0;
        shadow <= shadow_nx;
      end else if (mode == ADJUST) begin
        presc <= '0;
        {hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units} <= shadow;
      end else if (presc == TERM) begin
        presc <= '0;
        {hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units} <= inc_time;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_contador_relogio.sv
// Scoreboard bench for contador_relogio: a seconds-of-day reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_contador_relogio;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       ajMod;
  logic [3:0] in_ht, in_hu, in_mt, in_mu, in_st, in_su;
  logic [3:0] hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units;
  logic       sec_pulse, day_wrap;

  contador_relogio #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .ajMod(ajMod),
    .in_hou_tens(in_ht), .in_hou_units(in_hu),
    .in_min_tens(in_mt), .in_min_units(in_mu),
    .in_sec_tens(in_st), .in_sec_units(in_su),
    .hou_tens(hou_tens), .hou_units(hou_units),
    .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units),
    .sec_pulse(sec_pulse), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int secs;
    bit pulse;
    bit wrap;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: time of day in seconds, cycle count within the second.
  int m_secs = 0, m_presc = 0, m_sh = 0;
  bit m_adj = 0, m_pulse = 0, m_wrap = 0;

  function automatic logic [25:0] pack(int secs, bit p, bit w);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), p, w};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units, sec_pulse, day_wrap};
  endfunction

  function automatic bit hour_valid(int t, int u);
    return (t != 15) && (u <= 9) && (t * 10 + u <= 23);
  endfunction

  function automatic bit sexa_valid(int t, int u);
    return (t <= 5) && (u <= 9);
  endfunction

  task automatic model_step();
    int h, m, s;
    m_pulse = 0;
    m_wrap  = 0;
    if (ajMod) begin
      if (!m_adj) m_sh = m_secs;
      h = m_sh / 3600;
      m = (m_sh / 60) % 60;
      s = m_sh % 60;
      if (hour_valid(int'(in_ht), int'(in_hu))) h = int'(in_ht) * 10 + int'(in_hu);
      if (sexa_valid(int'(in_mt), int'(in_mu))) m = int'(in_mt) * 10 + int'(in_mu);
      if (sexa_valid(int'(in_st), int'(in_su))) s = int'(in_st) * 10 + int'(in_su);
      m_sh    = h * 3600 + m * 60 + s;
      m_presc = 0;
    end else if (m_adj) begin
      m_secs  = m_sh;
      m_presc = 0;
    end else if (m_presc == CLK_HZ - 1) begin
      m_presc = 0;
      m_secs  = (m_secs + 1) % 86400;
      m_pulse = 1;
      m_wrap  = (m_secs == 0);
    end else begin
      m_presc++;
    end
    m_adj = ajMod;
  endtask

  task automatic model_reset();
    m_secs = 0; m_presc = 0; m_sh = 0; m_adj = 0; m_pulse = 0; m_wrap = 0;
    q.delete();
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.secs = m_secs; e.pulse = m_pulse; e.wrap = m_wrap;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic check(string name, int secs, bit p, bit w);
    n_cmp++;
    if (dut_vec() !== pack(secs, p, w)) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, dut_vec(), pack(secs, p, w));
    end
  endtask

  task automatic set_dig(int ht, int hu, int mt, int mu, int st, int su);
    in_ht = 4'(ht); in_hu = 4'(hu); in_mt = 4'(mt);
    in_mu = 4'(mu); in_st = 4'(st); in_su = 4'(su);
  endtask

  task automatic set_in(int h, int m, int s);
    set_dig(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
  endtask

  task automatic set_blank();
    set_dig(15, 15, 15, 15, 15, 15);
  endtask

  task automatic load(int h, int m, int s);
    ajMod = 1'b1;
    set_in(h, m, s);
    step();
    ajMod = 1'b0;
    set_blank();
    step();
  endtask

  function automatic int rdig(int maxv);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 15;
    if (r == 1) return $urandom_range(0, 15);
    return $urandom_range(0, maxv);
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      n_cmp++;
      if (dut_vec() !== pack(mon_e.secs, mon_e.pulse, mon_e.wrap)) begin
        n_bad++;
        $display("FAIL scoreboard @%0t: got %h required %h", $time, dut_vec(),
                 pack(mon_e.secs, mon_e.pulse, mon_e.wrap));
      end
    end
  end

  initial begin
    ajMod = 1'b0;
    set_blank();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 check("reset_state", 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    repeat (10) step();
    check("first_second", 1, 1, 0);
    step();
    check("pulse_one_cycle", 1, 0, 0);
    repeat (589) step();
    check("one_minute", 60, 1, 0);

    load(23, 59, 59);
    check("load_235959", 86399, 0, 0);
    repeat (10) step();
    check("day_rollover", 0, 1, 1);
    load(9, 59, 59);
    check("load_095959", 9 * 3600 + 59 * 60 + 59, 0, 0);
    repeat (10) step();
    check("hour_tens_carry", 36000, 1, 0);

    ajMod = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) set_blank();
      else set_in(15, 30, 42);
      step();
    end
    ajMod = 1'b0;
    set_blank();
    step();
    check("blink_load", 15 * 3600 + 30 * 60 + 42, 0, 0);
    repeat (9) step();
    check("no_early_tick", 15 * 3600 + 30 * 60 + 42, 0, 0);
    step();
    check("tick_after_load", 15 * 3600 + 30 * 60 + 43, 1, 0);

    load(8, 20, 33);
    ajMod = 1'b1;
    set_dig(2, 7, 6, 0, 0, 9);
    repeat (3) step();
    ajMod = 1'b0;
    set_blank();
    step();
    check("invalid_pairs", 8 * 3600 + 20 * 60 + 9, 0, 0);

    repeat (9) step();
    ajMod = 1'b1;
    step();
    check("tick_collision", 8 * 3600 + 20 * 60 + 9, 0, 0);
    step();
    ajMod = 1'b0;
    step();
    check("blank_exit", 8 * 3600 + 20 * 60 + 9, 0, 0);
    repeat (10) step();
    check("tick_after_blank_exit", 8 * 3600 + 20 * 60 + 10, 1, 0);

    ajMod = 1'b1;
    set_in(12, 34, 56);
    repeat (2) step();
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_reset_mid_adjust", 0, 0, 0);
    ajMod = 1'b0;
    set_blank();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (9) step();
    check("post_reset_no_tick", 0, 0, 0);
    step();
    check("post_reset_second", 1, 1, 0);

    for (int it = 0; it < 40; it++) begin
      ajMod = 1'b0;
      set_dig(rdig(2), rdig(9), rdig(5), rdig(9), rdig(5), rdig(9));
      repeat ($urandom_range(1, 25)) step();
      ajMod = 1'b1;
      repeat ($urandom_range(1, 4)) begin
        set_dig(rdig(2), rdig(9), rdig(6), rdig(9), rdig(6), rdig(9));
        step();
      end
      ajMod = 1'b0;
      set_dig(rdig(2), rdig(9), rdig(5), rdig(9), rdig(5), rdig(9));
      step();
    end
    repeat (12) step();

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
